// File: rtl/bicubic_pkg.sv
// Shared widths and FSM encodings for the bicubic tile initiator slice.
package bicubic_pkg;
  localparam int CHANNEL_WIDTH = 8;
  localparam int BEATS         = 4;
  localparam int WIN_W         = 16 * CHANNEL_WIDTH;
  localparam int RSP_W         = 4 * CHANNEL_WIDTH;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] COLLECT = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;
endpackage

// File: rtl/bicubic_tile_initiator_if.sv
// Window, upsampler request/response and tile channels of the tile initiator.
interface bicubic_tile_initiator_if;
  import bicubic_pkg::*;

  // Every channel: a transfer happens in a cycle where valid and ready are both
  // high; valid stays high with stable data until that cycle.
  logic             win_valid;
  logic             win_ready;
  logic [WIN_W-1:0] win_data;
  logic             bf_req_valid;
  logic             bcci_req_ready;
  logic [WIN_W-1:0] bf_win;
  logic             bcci_rsp_valid;
  logic             bf_rsp_ready;
  logic [RSP_W-1:0] bcci_rsp_data;
  logic             tile_valid;
  logic             tile_ready;
  logic [WIN_W-1:0] tile_data;

  modport master (
    input  win_valid, win_data, bcci_req_ready, bcci_rsp_valid, bcci_rsp_data, tile_ready,
    output win_ready, bf_req_valid, bf_win, bf_rsp_ready, tile_valid, tile_data
  );

  modport slave (
    output win_valid, win_data, bcci_req_ready, bcci_rsp_valid, bcci_rsp_data, tile_ready,
    input  win_ready, bf_req_valid, bf_win, bf_rsp_ready, tile_valid, tile_data
  );
endinterface

// File: rtl/bicubic_tile_buf.sv
// 4x4 tile store: one column written per beat, whole tile read in parallel.
module bicubic_tile_buf
  import bicubic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_col,
  input  logic [RSP_W-1:0] wr_data,
  output logic [WIN_W-1:0] tile
);
  // Beat pixel r lands in row r of the addressed column: element (r,c) at r*4+c.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      dfflr #(.W(CHANNEL_WIDTH)) u_px (
        .clk  (clk),
        .rst  (rst),
        .lden (wr_en && (wr_col == 2'(c))),
        .d    (wr_data[r*CHANNEL_WIDTH +: CHANNEL_WIDTH]),
        .q    (tile[(r*4+c)*CHANNEL_WIDTH +: CHANNEL_WIDTH])
      );
    end
  end
endmodule

// File: rtl/dfflr.sv
// Load-enabled register with asynchronous active-high reset to zero.
module dfflr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lden,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (lden) q <= d;
  end
endmodule

// File: rtl/bicubic_tile_initiator.sv
// Requests one 4x4 upsample per window and assembles the 4-beat response into a tile.
// Define BCCI_TILE_CNT_EN to add the tile_cnt output (tile handshakes, wrapping).
module bicubic_tile_initiator
  import bicubic_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  bicubic_tile_initiator_if.master   bus,
  output logic [1:0]                 fsm_state
`ifdef BCCI_TILE_CNT_EN
  ,
  output logic [31:0]                tile_cnt
`endif
);
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       beat_cnt;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] tile_q;
  logic             win_hs;
  logic             req_hs;
  logic             beat_hs;
  logic             last_beat;
  logic             tile_hs;

  assign win_hs    = bus.win_valid      && (state == IDLE);
  assign req_hs    = bus.bcci_req_ready && (state == REQ);
  assign beat_hs   = bus.bcci_rsp_valid && (state == COLLECT);
  assign last_beat = beat_hs && (beat_cnt == 2'(BEATS - 1));
  assign tile_hs   = bus.tile_ready     && (state == OUT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_hs)    state_nxt = REQ;
      REQ:     if (req_hs)    state_nxt = COLLECT;
      COLLECT: if (last_beat) state_nxt = OUT;
      OUT:     if (tile_hs)   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  dfflr #(.W(2)) u_state (
    .clk (clk), .rst (rst), .lden (1'b1), .d (state_nxt), .q (state)
  );

  // Cleared on entry to COLLECT; the last beat wraps it back to 0 naturally.
  dfflr #(.W(2)) u_beat_cnt (
    .clk  (clk),
    .rst  (rst),
    .lden (req_hs || beat_hs),
    .d    (req_hs ? 2'd0 : beat_cnt + 2'd1),
    .q    (beat_cnt)
  );

  dfflr #(.W(WIN_W)) u_win (
    .clk (clk), .rst (rst), .lden (win_hs), .d (bus.win_data), .q (win_q)
  );

  bicubic_tile_buf u_tile_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (beat_hs),
    .wr_col  (beat_cnt),
    .wr_data (bus.bcci_rsp_data),
    .tile    (tile_q)
  );

  // All handshake outputs are pure state decodes: no ready-to-valid paths.
  assign bus.win_ready    = (state == IDLE);
  assign bus.bf_req_valid = (state == REQ);
  assign bus.bf_rsp_ready = (state == COLLECT);
  assign bus.tile_valid   = (state == OUT);
  assign bus.bf_win       = win_q;
  assign bus.tile_data    = tile_q;
  assign fsm_state        = state;

`ifdef BCCI_TILE_CNT_EN
  dfflr #(.W(32)) u_tile_cnt (
    .clk (clk), .rst (rst), .lden (tile_hs), .d (tile_cnt + 32'd1), .q (tile_cnt)
  );
`endif
endmodule

// File: tb/tb_bicubic_tile_initiator.sv
// Randomized bench for bicubic_tile_initiator against a tile-level reference model.
module tb_bicubic_tile_initiator;
  import bicubic_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bicubic_tile_initiator_if bus();
  logic [1:0] fsm_state;
`ifdef BCCI_TILE_CNT_EN
  logic [31:0] tile_cnt;
`endif

  bicubic_tile_initiator dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .fsm_state (fsm_state)
`ifdef BCCI_TILE_CNT_EN
    ,
    .tile_cnt  (tile_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  int               n_checks = 0;
  int               n_pass   = 0;
  int               cyc      = 0;
  logic [WIN_W-1:0] exp_q[$];
  logic [RSP_W-1:0] beat_buf[4];
  int               gap_buf[4];
  logic [31:0]      exp_cnt;

  task automatic check(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reference: beat c supplies column c, its J-th pixel goes to row J-1.
  function automatic logic [WIN_W-1:0] model_tile();
    logic [WIN_W-1:0] t;
    t = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[(r*4+c)*8 +: 8] = beat_buf[c][r*8 +: 8];
    return t;
  endfunction

  function automatic logic [WIN_W-1:0] rnd_win();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic randomize_beats();
    for (int j = 0; j < 4; j++) begin
      beat_buf[j] = $urandom;
      gap_buf[j]  = $urandom_range(0, 3);
    end
  endtask

  // ---------------- driver: one full transaction ----------------
  task automatic run_tile(input logic [WIN_W-1:0] win, input int req_delay, input int tile_delay,
                          input bit hold_next, input logic [WIN_W-1:0] next_win, input bit chk_lat);
    int               t_hs;
    int               lat_exp;
    logic [WIN_W-1:0] exp_tile;
    bus.win_valid = 1'b1;
    bus.win_data  = win;
    check("win_ready_idle", bus.win_ready, 1);
    t_hs = cyc;
    step();
    bus.win_valid = 1'b0;
    bus.win_data  = rnd_win();
    check("req_valid", bus.bf_req_valid, 1);
    check("bf_win", bus.bf_win, win);
    exp_q.push_back(model_tile());
    // junk beats while not collecting must be ignored
    bus.bcci_rsp_valid = 1'b1;
    bus.bcci_rsp_data  = $urandom;
    bus.bcci_req_ready = 1'b0;
    repeat (req_delay) begin
      bus.win_valid = 1'b1;
      step();
      check("req_valid_stall", bus.bf_req_valid, 1);
      check("bf_win_stall", bus.bf_win, win);
      check("win_ready_stall", bus.win_ready, 0);
    end
    bus.win_valid      = 1'b0;
    bus.bcci_req_ready = 1'b1;
    step();
    bus.bcci_req_ready = 1'b0;
    bus.bcci_rsp_valid = 1'b0;
    check("rsp_ready", bus.bf_rsp_ready, 1);
    check("req_valid_low", bus.bf_req_valid, 0);
    lat_exp = 6 + req_delay;
    for (int j = 0; j < 4; j++) begin
      repeat (gap_buf[j]) begin
        bus.bcci_rsp_valid = 1'b0;
        step();
      end
      lat_exp += gap_buf[j];
      bus.bcci_rsp_valid = 1'b1;
      bus.bcci_rsp_data  = beat_buf[j];
      step();
    end
    // a fifth beat stays offered through the whole OUT phase
    bus.bcci_rsp_data = $urandom;
    check("tile_valid", bus.tile_valid, 1);
    check("rsp_ready_out", bus.bf_rsp_ready, 0);
    if (chk_lat) check("tile_latency", WIN_W'(cyc - t_hs), WIN_W'(lat_exp));
    exp_tile = exp_q[0];
    bus.tile_ready = 1'b0;
    if (hold_next) begin
      bus.win_valid = 1'b1;
      bus.win_data  = next_win;
    end
    repeat (tile_delay) begin
      step();
      check("tile_valid_stall", bus.tile_valid, 1);
      check("tile_data_stall", bus.tile_data, exp_tile);
      check("win_ready_out", bus.win_ready, 0);
    end
    check("tile_data", bus.tile_data, exp_q.pop_front());
    bus.tile_ready = 1'b1;
    step();
    bus.tile_ready     = 1'b0;
    bus.bcci_rsp_valid = 1'b0;
    exp_cnt++;
    check("tile_valid_drop", bus.tile_valid, 0);
    check("win_ready_after", bus.win_ready, 1);
`ifdef BCCI_TILE_CNT_EN
    check("tile_cnt", tile_cnt, exp_cnt);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_win_ready"}, bus.win_ready, 1);
    check({tag, "_req_valid"}, bus.bf_req_valid, 0);
    check({tag, "_rsp_ready"}, bus.bf_rsp_ready, 0);
    check({tag, "_tile_valid"}, bus.tile_valid, 0);
    check({tag, "_bf_win"}, bus.bf_win, 0);
    check({tag, "_tile_data"}, bus.tile_data, 0);
    check({tag, "_state"}, fsm_state, IDLE);
`ifdef BCCI_TILE_CNT_EN
    check({tag, "_tile_cnt"}, tile_cnt, 0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIN_W-1:0] cur_win;
    logic [WIN_W-1:0] nxt_win;
    logic [WIN_W-1:0] exp_t;
    rst                = 1'b1;
    bus.win_valid      = 1'b0;
    bus.win_data       = '0;
    bus.bcci_req_ready = 1'b0;
    bus.bcci_rsp_valid = 1'b0;
    bus.bcci_rsp_data  = '0;
    bus.tile_ready     = 1'b0;
    exp_cnt            = '0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // flat window, upsampler answers one cycle after the request
    for (int j = 0; j < 4; j++) begin
      beat_buf[j] = {4{8'd100}};
      gap_buf[j]  = (j == 0) ? 1 : 0;
    end
    run_tile({16{8'd100}}, 0, 0, 1'b0, '0, 1'b1);

    // transposition pattern, stalled request, gaps of 0 and 3
    for (int c = 0; c < 4; c++)
      beat_buf[c] = {8'(16*c+3), 8'(16*c+2), 8'(16*c+1), 8'(16*c)};
    gap_buf[0] = 0; gap_buf[1] = 3; gap_buf[2] = 0; gap_buf[3] = 3;
    exp_t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_t[(r*4+c)*8 +: 8] = 8'(16*c + r);
    check("transpose_model", model_tile(), exp_t);
    run_tile(rnd_win(), 5, 0, 1'b0, '0, 1'b1);

    // long tile stall with the next window already waiting, then random traffic
    randomize_beats();
    cur_win = rnd_win();
    nxt_win = rnd_win();
    run_tile(cur_win, 1, 10, 1'b1, nxt_win, 1'b1);
    cur_win = nxt_win;
    for (int k = 0; k < 8; k++) begin
      randomize_beats();
      nxt_win = rnd_win();
      run_tile(cur_win, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, nxt_win, 1'b1);
      cur_win = nxt_win;
    end
    randomize_beats();
    run_tile(cur_win, 0, 0, 1'b0, '0, 1'b1);

    // reset during COLLECT after two beats
    randomize_beats();
    bus.win_valid = 1'b1;
    bus.win_data  = rnd_win();
    step();
    bus.win_valid      = 1'b0;
    bus.bcci_req_ready = 1'b1;
    step();
    bus.bcci_req_ready = 1'b0;
    for (int j = 0; j < 2; j++) begin
      bus.bcci_rsp_valid = 1'b1;
      bus.bcci_rsp_data  = beat_buf[j];
      step();
    end
    check("mid_state", fsm_state, COLLECT);
    #2;
    rst = 1'b1;
    bus.bcci_rsp_valid = 1'b0;
    #1;
    exp_cnt = '0;
    check_reset_outputs("midrst");
    step();
    rst = 1'b0;
    step();
    randomize_beats();
    run_tile(rnd_win(), $urandom_range(0, 3), 1, 1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
